lofi_crusher: RTL and testbench

LOFI_CRUSHER -- requirements
Module: lofi_crusher

---
 rtl/lofi_pkg.sv | 12 +
 rtl/lofi_quantizer.sv | 36 +++
 rtl/lofi_crusher.sv | 131 +++++++++++++
 tb/tb_lofi_crusher.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lofi_pkg.sv
// Shared constants for the lo-fi bit/sample-rate crusher.
package lofi_pkg;

  localparam int LOFI_LATENCY = 3;
  localparam int MIX_UNITY    = 256;

  typedef enum logic {
    MODE_TRUNCATE = 1'b0,
    MODE_ROUND    = 1'b1
  } quant_mode_t;

endpackage

// File: rtl/lofi_quantizer.sv
// Combinational bit-depth reducer: keeps bit_depth+1 MSBs, truncating or rounding.
module lofi_quantizer
  import lofi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int BD_W = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] audio_in,
  input  logic [BD_W-1:0]       bit_depth,
  input  logic                  round_en,
  output logic [DATA_WIDTH-1:0] quant
);

  logic [BD_W-1:0]       shift;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] half;
  logic [DATA_WIDTH-1:0] sum;
  logic                  overflow;

  always_comb begin
    shift    = BD_W'(DATA_WIDTH - 1) - bit_depth;
    mask     = '1 << shift;
    half     = DATA_WIDTH'(1) << (shift - 1'b1);
    sum      = audio_in + half;
    // only a non-negative input can wrap past the positive limit
    overflow = ~audio_in[DATA_WIDTH-1] & sum[DATA_WIDTH-1];
    quant    = audio_in;
    if (32'(bit_depth) < DATA_WIDTH - 1) begin
      if (round_en == MODE_ROUND)
        quant = overflow ? ({1'b0, {(DATA_WIDTH-1){1'b1}}} & mask) : (sum & mask);
      else
        quant = audio_in & mask;
    end
  end

endmodule

// File: rtl/lofi_crusher.sv
// Three-stage multichannel crusher: quantize, per-channel sample-and-hold, dry/wet mix.
module lofi_crusher
  import lofi_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int HOLD_WIDTH   = 8,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int BD_W = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  sample_valid,
  input  logic [CH_W-1:0]       ch_in,
  input  logic [DATA_WIDTH-1:0] audio_in,
  input  logic [BD_W-1:0]       bit_depth,
  input  logic                  round_en,
  input  logic [HOLD_WIDTH-1:0] rate_div,
  input  logic [8:0]            mix,
  output logic [DATA_WIDTH-1:0] audio_out,
  output logic                  audio_out_valid,
  output logic [CH_W-1:0]       ch_out
);

  localparam int PW = DATA_WIDTH + 11;

  logic [DATA_WIDTH-1:0] quant;
  logic                  accept;

  logic                  v1, v2;
  logic [CH_W-1:0]       ch1, ch2;
  logic [DATA_WIDTH-1:0] q1, dry1, wet2, dry2;
  logic [HOLD_WIDTH-1:0] rate1;
  logic [8:0]            m1, m2;

  logic [HOLD_WIDTH-1:0] cnt  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] held [NUM_CHANNELS];

  logic [HOLD_WIDTH-1:0] cur_cnt, next_cnt;
  logic [DATA_WIDTH-1:0] wet;
  logic signed [DATA_WIDTH:0] diff;
  logic signed [PW-1:0]  prod, mixed;

  lofi_quantizer #(.DATA_WIDTH(DATA_WIDTH)) u_quant (
    .audio_in (audio_in),
    .bit_depth(bit_depth),
    .round_en (round_en),
    .quant    (quant)
  );

  assign accept = sample_valid && !flush && (32'(ch_in) < 32'(NUM_CHANNELS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      ch1   <= '0;
      q1    <= '0;
      dry1  <= '0;
      rate1 <= '0;
      m1    <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        ch1   <= ch_in;
        q1    <= quant;
        dry1  <= audio_in;
        rate1 <= rate_div;
        m1    <= (mix > 9'(MIX_UNITY)) ? 9'(MIX_UNITY) : mix;
      end
    end
  end

  // ">=" rather than "==" so a lowered rate_div cannot strand a counter above it
  always_comb begin
    cur_cnt  = cnt[ch1];
    wet      = (cur_cnt == '0) ? q1 : held[ch1];
    next_cnt = (cur_cnt >= rate1) ? '0 : cur_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        cnt[i]  <= '0;
        held[i] <= '0;
      end
      v2   <= 1'b0;
      ch2  <= '0;
      wet2 <= '0;
      dry2 <= '0;
      m2   <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        cnt[i]  <= '0;
        held[i] <= '0;
      end
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        cnt[ch1] <= next_cnt;
        if (cur_cnt == '0) held[ch1] <= q1;
        ch2  <= ch1;
        wet2 <= wet;
        dry2 <= dry1;
        m2   <= m1;
      end
    end
  end

  always_comb begin
    diff  = (DATA_WIDTH+1)'(signed'(wet2)) - (DATA_WIDTH+1)'(signed'(dry2));
    prod  = PW'(diff) * PW'(signed'({1'b0, m2}));
    mixed = PW'(signed'(dry2)) + (prod >>> 8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio_out       <= '0;
      audio_out_valid <= 1'b0;
      ch_out          <= '0;
    end else begin
      audio_out_valid <= v2 && !flush;
      if (v2 && !flush) begin
        audio_out <= mixed[DATA_WIDTH-1:0];
        ch_out    <= ch2;
      end
    end
  end

endmodule

// File: tb/tb_lofi_crusher.sv
// Directed bench for lofi_crusher (32-bit, 3 channels) with hand-computed expectations.
module tb_lofi_crusher;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        sample_valid;
  logic [1:0]  ch_in;
  logic [31:0] audio_in;
  logic [4:0]  bit_depth;
  logic        round_en;
  logic [7:0]  rate_div;
  logic [8:0]  mix;
  logic [31:0] audio_out;
  logic        audio_out_valid;
  logic [1:0]  ch_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_send = 0;
  int send_cyc = 0;

  logic [31:0] q_data[$];
  logic [1:0]  q_ch[$];
  int          q_cyc[$];

  lofi_crusher #(.DATA_WIDTH(32), .NUM_CHANNELS(3), .HOLD_WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .sample_valid   (sample_valid),
    .ch_in          (ch_in),
    .audio_in       (audio_in),
    .bit_depth      (bit_depth),
    .round_en       (round_en),
    .rate_div       (rate_div),
    .mix            (mix),
    .audio_out      (audio_out),
    .audio_out_valid(audio_out_valid),
    .ch_out         (ch_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (audio_out_valid) begin
      q_data.push_back(audio_out);
      q_ch.push_back(ch_out);
      q_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [1:0] c, input logic [31:0] d);
    sample_valid = 1'b1;
    ch_in        = c;
    audio_in     = d;
    last_send    = cyc;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic clear_log();
    q_data.delete();
    q_ch.delete();
    q_cyc.delete();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] c, input logic [31:0] v);
    logic [31:0] d;
    logic [1:0]  o;
    if (q_data.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed no output expected %h", tag, v);
    end else begin
      d = q_data.pop_front();
      o = q_ch.pop_front();
      void'(q_cyc.pop_front());
      check(tag, {30'd0, o, d}, {30'd0, c, v});
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; sample_valid = 1'b0; ch_in = '0; audio_in = '0;
    bit_depth = 5'd31; round_en = 1'b0; rate_div = 8'd0; mix = 9'd256;
    idle(2);
    check("reset_valid", 64'(audio_out_valid), 64'd0);
    check("reset_data", 64'(audio_out), 64'd0);
    check("reset_ch", 64'(ch_out), 64'd0);
    rst = 1'b0;
    idle(1);

    // truncate with latency
    clear_log();
    bit_depth = 5'd7;
    send(2'd0, 32'h1234_5678);
    send_cyc = last_send;
    idle(5);
    if (q_cyc.size() > 0) check("latency", 64'(q_cyc[0] - send_cyc), 64'd3);
    else check("latency", 64'(q_cyc.size()), 64'd1);
    expect_out("trunc", 2'd0, 32'h1200_0000);

    // rounding, saturation, controls travelling with each sample
    round_en = 1'b1;
    send(2'd0, 32'h7FFF_FFFF);
    send(2'd0, 32'h1280_0000);
    send(2'd1, 32'hFF80_0000);
    round_en = 1'b0;
    send(2'd1, 32'h1280_0000);
    idle(5);
    expect_out("round_sat", 2'd0, 32'h7F00_0000);
    expect_out("round_up", 2'd0, 32'h1300_0000);
    expect_out("round_neg", 2'd1, 32'h0000_0000);
    expect_out("trunc_after_round", 2'd1, 32'h1200_0000);

    // sample-and-hold with independent channel phases
    do_flush();
    clear_log();
    bit_depth = 5'd31;
    rate_div  = 8'd3;
    send(2'd1, 32'd100);
    for (int k = 1; k <= 8; k++) begin
      send(2'd0, 32'(k));
      send(2'd1, 32'(100 + k));
    end
    idle(5);
    expect_out("hold_ch1_first", 2'd1, 32'd100);
    for (int k = 1; k <= 8; k++) begin
      expect_out($sformatf("hold_ch0_%0d", k), 2'd0, 32'(((k - 1) / 4) * 4 + 1));
      expect_out($sformatf("hold_ch1_%0d", k), 2'd1, 32'(100 + (k / 4) * 4));
    end

    // lowering rate_div below the running count
    do_flush();
    clear_log();
    rate_div = 8'd7;
    for (int k = 1; k <= 5; k++) send(2'd0, 32'(10 * k));
    rate_div = 8'd1;
    send(2'd0, 32'd60);
    send(2'd0, 32'd70);
    idle(5);
    for (int k = 1; k <= 5; k++) expect_out($sformatf("rate7_%0d", k), 2'd0, 32'd10);
    expect_out("rate_drop_reset", 2'd0, 32'd10);
    expect_out("rate_drop_load", 2'd0, 32'd70);

    // dry/wet mix
    do_flush();
    clear_log();
    rate_div  = 8'd0;
    bit_depth = 5'd7;
    mix = 9'd0;   send(2'd0, 32'h1234_5678);
    mix = 9'd128; send(2'd0, 32'd1000);
    mix = 9'd300; send(2'd0, 32'h1234_5678);
    mix = 9'd128; send(2'd2, 32'h0180_0000);
    mix = 9'd256;
    idle(5);
    expect_out("mix0_dry", 2'd0, 32'h1234_5678);
    expect_out("mix128", 2'd0, 32'd500);
    expect_out("mix300_wet", 2'd0, 32'h1200_0000);
    expect_out("mix128_neg_diff", 2'd2, 32'h0140_0000);

    // invalid channel and flush-dropped samples
    do_flush();
    clear_log();
    bit_depth = 5'd31;
    rate_div  = 8'd3;
    send(2'd3, 32'd5);
    idle(5);
    check("bad_channel_dropped", 64'(q_data.size()), 64'd0);
    send(2'd2, 32'd33);
    idle(4);
    flush = 1'b1;
    send(2'd2, 32'd44);
    flush = 1'b0;
    send(2'd2, 32'd55);
    idle(5);
    expect_out("pre_flush", 2'd2, 32'd33);
    expect_out("post_flush_fresh", 2'd2, 32'd55);
    check("flush_no_extra", 64'(q_data.size()), 64'd0);

    // asynchronous reset mid-stream
    clear_log();
    send(2'd0, 32'd40);
    idle(4);
    expect_out("pre_rst", 2'd0, 32'd40);
    send(2'd0, 32'd50);
    send(2'd1, 32'd60);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(audio_out_valid), 64'd0);
    check("async_rst_data", 64'(audio_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("rst_discard", 64'(q_data.size()), 64'd0);
    send(2'd0, 32'd70);
    send(2'd1, 32'd80);
    idle(5);
    expect_out("post_rst_ch0", 2'd0, 32'd70);
    expect_out("post_rst_ch1", 2'd1, 32'd80);
    check("no_leftover", 64'(q_data.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
